// File: rtl/dbus_ram_rsp_if.sv
// dbus_ram_rsp_if: dbus req/rsp handshake between core MEM stage and RAM.
// Signals: addr/wdata/sel/we/req (master->slave), rdata/rsp/err (slave->master).
// err exists only when DBUS_RSP_ALIGN_CHK_EN is defined.
interface dbus_ram_rsp_if;
  logic [31:0] i_dbus_addr;
  logic [31:0] i_dbus_wdata;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_req;
  logic [31:0] o_dbus_rdata;
  logic        o_dbus_rsp;
`ifdef DBUS_RSP_ALIGN_CHK_EN
  logic        o_dbus_err;
`endif

  modport master (
    output i_dbus_addr, i_dbus_wdata,
    output i_dbus_sel, i_dbus_we, i_dbus_req,
`ifdef DBUS_RSP_ALIGN_CHK_EN
    input  o_dbus_err,
`endif
    input  o_dbus_rdata, o_dbus_rsp
  );

  modport slave (
    input  i_dbus_addr, i_dbus_wdata,
    input  i_dbus_sel, i_dbus_we, i_dbus_req,
`ifdef DBUS_RSP_ALIGN_CHK_EN
    output o_dbus_err,
`endif
    output o_dbus_rdata, o_dbus_rsp
  );
endinterface

// File: rtl/dbus_ram_rsp.sv
// dbus_ram_rsp: dbus slave with internal word RAM, one access in flight.
// Ports: i_clk, i_rst (sync, active-high), bus (dbus_ram_rsp_if.slave).
// Params: DEPTH words (power of two), WAIT_CYCLES 0..15 wait states.
// Option: DBUS_RSP_ALIGN_CHK_EN adds o_dbus_err and sel/align checking.
module dbus_ram_rsp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dbus_ram_rsp_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [3:0] LP_WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_rsp;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_accept;
  logic              w_err;
  logic              w_last;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_we;
  logic              w_rd_err;
  logic              w_unused_addr;

  assign w_idx    = bus.i_dbus_addr[ADDR_W+1:2];
  assign w_accept = (r_state == S_IDLE) && bus.i_dbus_req;
  assign w_unused_addr = ^{bus.i_dbus_addr[31:ADDR_W+2],
                           bus.i_dbus_addr[1:0]};

`ifdef DBUS_RSP_ALIGN_CHK_EN
  logic w_sel_ok;
  always_comb begin
    w_sel_ok = 1'b0;
    unique case (1'b1)
      bus.i_dbus_sel == 4'b0001,
      bus.i_dbus_sel == 4'b0010,
      bus.i_dbus_sel == 4'b0100,
      bus.i_dbus_sel == 4'b1000,
      bus.i_dbus_sel == 4'b0011,
      bus.i_dbus_sel == 4'b1100: w_sel_ok = 1'b1;
      bus.i_dbus_sel == 4'b1111:
        w_sel_ok = (bus.i_dbus_addr[1:0] == 2'b00);
      default: w_sel_ok = 1'b0;
    endcase
  end
  assign w_err = ~w_sel_ok;
`else
  assign w_err = 1'b0;
`endif

  // Last cycle before RESP: the accept cycle itself when there are no
  // wait states, else the WAIT cycle where the counter hits zero.
  assign w_last = (w_accept && (WAIT_CYCLES == 0)) ||
                  ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // In IDLE the request is not captured yet, so read it off the bus.
  assign w_rd_idx = (r_state == S_IDLE) ? w_idx : r_idx;
  assign w_rd_we  = (r_state == S_IDLE) ? bus.i_dbus_we : r_we;
  assign w_rd_err = (r_state == S_IDLE) ? w_err : r_err;

`ifdef DBUS_RSP_ALIGN_CHK_EN
  logic r_err_o;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rsp   <= 1'b0;
      r_rdata <= 32'd0;
`ifdef DBUS_RSP_ALIGN_CHK_EN
      r_err_o <= 1'b0;
`endif
    end else begin
      r_rsp <= 1'b0;
`ifdef DBUS_RSP_ALIGN_CHK_EN
      r_err_o <= 1'b0;
`endif
      if (w_last) begin
        r_rsp <= 1'b1;
`ifdef DBUS_RSP_ALIGN_CHK_EN
        r_err_o <= w_rd_err;
`endif
        if (!w_rd_we)
          r_rdata <= w_rd_err ? 32'd0 : r_mem[w_rd_idx];
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_dbus_req) begin
            r_idx   <= w_idx;
            r_we    <= bus.i_dbus_we;
            r_sel   <= bus.i_dbus_sel;
            r_wdata <= bus.i_dbus_wdata;
            r_err   <= w_err;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= LP_WLOAD;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= S_RESP;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store commits on the edge ending RESP; reset wins over the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_RESP) && r_we && !r_err) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k])
          r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign bus.o_dbus_rsp   = r_rsp;
  assign bus.o_dbus_rdata = r_rdata;
`ifdef DBUS_RSP_ALIGN_CHK_EN
  assign bus.o_dbus_err   = r_err_o;
`endif
endmodule

// File: tb/tb_dbus_ram_rsp.sv
// tb_dbus_ram_rsp: scoreboard bench for dbus_ram_rsp.
// Runs one instance with WAIT_CYCLES=0 and one with WAIT_CYCLES=3.
module tb_dbus_ram_rsp;
  logic clk = 1'b0;
  logic rst0;
  logic rst3;
  always #5 clk = ~clk;

  dbus_ram_rsp_if b0 ();
  dbus_ram_rsp_if b3 ();

  dbus_ram_rsp #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .i_clk(clk), .i_rst(rst0), .bus(b0)
  );
  dbus_ram_rsp #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (
    .i_clk(clk), .i_rst(rst3), .bus(b3)
  );

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tot = 0;
  int          n_bad = 0;
  logic [31:0] last [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(int w, logic req, logic we, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] s);
    if (w == 0) begin
      b0.i_dbus_req = req; b0.i_dbus_we = we; b0.i_dbus_addr = a;
      b0.i_dbus_wdata = wd; b0.i_dbus_sel = s;
    end else begin
      b3.i_dbus_req = req; b3.i_dbus_we = we; b3.i_dbus_addr = a;
      b3.i_dbus_wdata = wd; b3.i_dbus_sel = s;
    end
  endtask

  function automatic logic rsp_of(int w);
    return (w == 0) ? b0.o_dbus_rsp : b3.o_dbus_rsp;
  endfunction

  function automatic logic [31:0] rd_of(int w);
    return (w == 0) ? b0.o_dbus_rdata : b3.o_dbus_rdata;
  endfunction

`ifdef DBUS_RSP_ALIGN_CHK_EN
  function automatic logic err_of(int w);
    return (w == 0) ? b0.o_dbus_err : b3.o_dbus_err;
  endfunction
`endif

  task automatic pop_chk(int w, int lat, string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_rd"}, rd_of(w), e.rd);
`ifdef DBUS_RSP_ALIGN_CHK_EN
    chk({tag, "_err"}, 32'(err_of(w)), 32'(e.er));
`endif
  endtask

  // One access; stores expect rdata to keep the last load value.
  task automatic acc(int w, logic we, logic [31:0] a, logic [31:0] wd,
                     logic [3:0] s, logic [31:0] exp_rd, logic exp_er,
                     string tag);
    int   n;
    bit   got;
    int   li;
    exp_t e;
    li = (w == 0) ? 0 : 1;
    if (!we) last[li] = exp_rd;
    e.rd  = last[li];
    e.er  = exp_er;
    e.lat = (w == 0) ? 1 : 4;
    @(negedge clk);
    drive(w, 1'b1, we, a, wd, s);
    sb.push_back(e);
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rsp_of(w)) got = 1;
    end
    drive(w, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    if (got) pop_chk(w, n, tag);
    else begin
      void'(sb.pop_front());
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(rsp_of(w)), 32'd0);
  endtask

  initial begin
    int   n;
    int   seen;
    exp_t e;
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    last[0] = 32'd0;
    last[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp0", 32'(b0.o_dbus_rsp), 32'd0);
    chk("rst_rd0", b0.o_dbus_rdata, 32'd0);
    chk("rst_rsp3", 32'(b3.o_dbus_rsp), 32'd0);
    chk("rst_rd3", b3.o_dbus_rdata, 32'd0);
`ifdef DBUS_RSP_ALIGN_CHK_EN
    chk("rst_err0", 32'(b0.o_dbus_err), 32'd0);
`endif
    @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;

    acc(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 0, "st10");
    acc(0, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 0, "ld10");

    // reset in the RESP cycle of a store must block the write
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    chk("rresp_rsp", 32'(b0.o_dbus_rsp), 32'd1);
    @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    chk("rresp_rsp0", 32'(b0.o_dbus_rsp), 32'd0);
    chk("rresp_rd0", b0.o_dbus_rdata, 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    last[0] = 32'd0;
    acc(0, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 0, "rresp_nowr");

    // req during reset is not taken; taken on the first cycle after
    @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    @(posedge clk); #1;
    chk("rreq_rsp", 32'(b0.o_dbus_rsp), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    @(posedge clk); #1;
    chk("rreq_acc", 32'(b0.o_dbus_rsp), 32'd1);
    chk("rreq_rd", b0.o_dbus_rdata, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    last[0] = 32'hDEADBEEF;

    acc(0, 1, 32'h20, 32'h11223344, 4'hF, 32'd0, 0, "st20");
    acc(0, 1, 32'h20, 32'h00AA0000, 4'b0100, 32'd0, 0, "st20b");
    acc(0, 0, 32'h20, 32'd0, 4'hF, 32'h11AA3344, 0, "ld20");
    acc(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'd0, 0, "st20z");
    acc(0, 0, 32'h20, 32'd0, 4'hF, 32'h11AA3344, 0, "ld20z");
    acc(0, 1, 32'h1000, 32'h5, 4'hF, 32'd0, 0, "st_alias");
    acc(0, 0, 32'h0, 32'd0, 4'hF, 32'h5, 0, "ld_alias");

`ifdef DBUS_RSP_ALIGN_CHK_EN
    acc(0, 1, 32'h40, 32'h12345678, 4'hF, 32'd0, 0, "ck_st");
    acc(0, 1, 32'h42, 32'hFFFFFFFF, 4'hF, 32'd0, 1, "ck_mis");
    acc(0, 0, 32'h40, 32'd0, 4'hF, 32'h12345678, 0, "ck_ld");
    acc(0, 0, 32'h40, 32'd0, 4'b0110, 32'd0, 1, "ck_sel");
    acc(0, 1, 32'h42, 32'hABCD0000, 4'b1100, 32'd0, 0, "ck_hi");
    acc(0, 0, 32'h40, 32'd0, 4'hF, 32'hABCD5678, 0, "ck_ld2");
`endif

    // WAIT_CYCLES=3: addr changes during WAIT, back-to-back req
    acc(3, 1, 32'h80, 32'h0BADF00D, 4'hF, 32'd0, 0, "st80");
    acc(3, 1, 32'h84, 32'hCAFE0001, 4'hF, 32'd0, 0, "st84");
    @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'h80, 32'd0, 4'hF);
    e.er = 1'b0;
    e.rd = 32'h0BADF00D; e.lat = 4; sb.push_back(e);
    e.rd = 32'hCAFE0001; e.lat = 9; sb.push_back(e);
    n = 0;
    seen = 0;
    while (seen < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) b3.i_dbus_addr = 32'h84;
      if (n == 2) b3.i_dbus_addr = 32'h88;
      if (n == 3) b3.i_dbus_addr = 32'h84;
      if (b3.o_dbus_rsp) begin
        pop_chk(3, n, (seen == 0) ? "b2b_a" : "b2b_b");
        seen++;
      end
      if (seen == 2) drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end
    if (seen < 2) begin
      chk("b2b_timeout", 32'(seen), 32'd2);
      drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      sb.delete();
    end
    @(posedge clk); #1;
    last[1] = 32'hCAFE0001;

    for (int i = 0; i < 8; i++)
      acc(3, 1, 32'h100 + 32'(4*i), 32'h01010101 * 32'(i+1), 4'hF,
          32'd0, 0, "st_blk");
    for (int i = 0; i < 8; i++)
      acc(3, 0, 32'h100 + 32'(4*i), 32'd0, 4'hF,
          32'h01010101 * 32'(i+1), 0, "ld_blk");

    // reset during WAIT of a store: no rsp, no write
    acc(3, 1, 32'h40, 32'h1234, 4'hF, 32'd0, 0, "st40");
    @(negedge clk);
    drive(3, 1'b1, 1'b1, 32'h40, 32'h9999, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b3.o_dbus_rsp) seen++;
    end
    chk("abort_rsp", 32'(seen), 32'd0);
    chk("abort_rd", b3.o_dbus_rdata, 32'd0);
    last[1] = 32'd0;
    acc(3, 0, 32'h40, 32'd0, 4'hF, 32'h1234, 0, "ld40");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
